// File: rtl/dec_seq_onehot_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec_seq_pkg
// Brief    : Mode/state encodings shared by the sequenced one-hot decoder.
// Revision : 1.0
// ============================================================================
package dec_seq_pkg;

    localparam logic [1:0] c_MODE_HOLD  = 2'b00;
    localparam logic [1:0] c_MODE_PULSE = 2'b01;
    localparam logic [1:0] c_MODE_SCAN  = 2'b10;
    localparam logic [1:0] c_MODE_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        MODE_HOLD  = c_MODE_HOLD,
        MODE_PULSE = c_MODE_PULSE,
        MODE_SCAN  = c_MODE_SCAN,
        MODE_RSVD  = c_MODE_RSVD
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_PULSE = 2'd2,
        ST_SCAN  = 2'd3
    } state_e;

    // The reserved mode collapses onto HOLD.
    function automatic state_e mode_to_state(input mode_e m);
        case (m)
            MODE_PULSE: return ST_PULSE;
            MODE_SCAN:  return ST_SCAN;
            default:    return ST_HOLD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dec_seq_onehot_if.sv
`default_nettype none
// ============================================================================
// Module   : dec_seq_onehot_if
// Brief    : Load handshake and select outputs of the sequenced decoder.
// Revision : 1.0
// ============================================================================
interface dec_seq_onehot_if
    import dec_seq_pkg::*;
#(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 2**SEL_W;

    logic             en;
    mode_e            mode;
    logic [SEL_W-1:0] sel;
    logic             load_valid;
    logic             load_ready;
    logic [OUT_W-1:0] y;
    logic [SEL_W-1:0] idx;
    logic             busy;
    logic             wrap;

    modport master (
        output en, mode, sel, load_valid,
        input  load_ready, y, idx, busy, wrap
    );

    modport slave (
        input  en, mode, sel, load_valid,
        output load_ready, y, idx, busy, wrap
    );

endinterface
`default_nettype wire

// File: rtl/dec_seq_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : dec_n_onehot
// Brief    : Combinational N-to-2^N one-hot decoder with enable.
// Revision : 1.0
// ============================================================================
module dec_n_onehot #(
    parameter int SEL_W = 3
) (
    input  wire logic [SEL_W-1:0]    idx_i,
    input  wire logic                en_i,
    output logic      [2**SEL_W-1:0] y_o
);
    localparam int OUT_W = 2**SEL_W;

    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o = OUT_W'(1) << idx_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dec_seq_onehot.sv
`default_nettype none
// ============================================================================
// Module   : dec_seq_onehot
// Brief    : Registered one-hot decoder sequencing HOLD / PULSE / SCAN modes.
// Revision : 1.0
// ============================================================================
module dec_seq_onehot
    import dec_seq_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int DWELL     = 4,
    parameter int PULSE_LEN = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    dec_seq_onehot_if.slave   bus
);
    localparam int OUT_W     = 2**SEL_W;
    localparam int c_CNT_MAX = (DWELL > PULSE_LEN) ? DWELL : PULSE_LEN;
    localparam int CNT_W     = $clog2(c_CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] c_PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [SEL_W-1:0] c_IDX_LAST   = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [SEL_W-1:0] idx_q,   idx_d;
    logic [OUT_W-1:0] y_q,     y_d;
    logic             busy_q,  busy_d;
    logic             wrap_q,  wrap_d;
    logic             load_acc;

    assign bus.load_ready = bus.en && (state_q != ST_PULSE);
    assign load_acc       = bus.load_valid && bus.load_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        if (!bus.en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (load_acc) begin
            state_d = mode_to_state(bus.mode);
            cnt_d   = '0;
            idx_d   = bus.sel;
        end else begin
            case (state_q)
                ST_PULSE: begin
                    if (cnt_q == c_PULSE_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (cnt_q == c_DWELL_LAST) begin
                        cnt_d  = '0;
                        idx_d  = idx_q + SEL_W'(1);
                        wrap_d = (idx_q == c_IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // Decoding the next index keeps y aligned with idx in the same register stage.
    dec_n_onehot #(
        .SEL_W (SEL_W)
    ) u_dec (
        .idx_i (idx_d),
        .en_i  (busy_d),
        .y_o   (y_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.y    = y_q;
    assign bus.idx  = idx_q;
    assign bus.busy = busy_q;
    assign bus.wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_dec_seq_onehot.sv
`default_nettype none
// ============================================================================
// Module   : tb_dec_seq_onehot
// Brief    : Directed and random checks of dec_seq_onehot at SEL_W=3 and 4.
// Revision : 1.0
// ============================================================================
module tb_dec_seq_onehot;
    import dec_seq_pkg::*;

    localparam int DWELL     = 4;
    localparam int PULSE_LEN = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       d_en   [2];
    logic       d_lv   [2];
    logic [1:0] d_mode [2];
    logic [3:0] d_sel  [2];

    dec_seq_onehot_if #(.SEL_W(3)) bus3 ();
    dec_seq_onehot_if #(.SEL_W(4)) bus4 ();

    assign bus3.en         = d_en[0];
    assign bus3.load_valid = d_lv[0];
    assign bus3.mode       = mode_e'(d_mode[0]);
    assign bus3.sel        = d_sel[0][2:0];
    assign bus4.en         = d_en[1];
    assign bus4.load_valid = d_lv[1];
    assign bus4.mode       = mode_e'(d_mode[1]);
    assign bus4.sel        = d_sel[1];

    dec_seq_onehot #(.SEL_W(3), .DWELL(DWELL), .PULSE_LEN(PULSE_LEN)) dut3 (
        .clk (clk), .rst_n (rst_n), .bus (bus3)
    );
    dec_seq_onehot #(.SEL_W(4), .DWELL(DWELL), .PULSE_LEN(PULSE_LEN)) dut4 (
        .clk (clk), .rst_n (rst_n), .bus (bus4)
    );

    // Reference: mode, target and cycles elapsed since the accepting edge.
    bit m_act  [2];
    int m_mode [2];
    int m_sel  [2];
    int m_t    [2];

    function automatic int ow(int k);
        return (k == 0) ? 8 : 16;
    endfunction

    function automatic bit m_ready(int k);
        return d_en[k] && !(m_act[k] && m_mode[k] == 1);
    endfunction

    function automatic int m_idx(int k);
        if (!m_act[k]) return 0;
        if (m_mode[k] == 2) return (m_sel[k] + (m_t[k] - 1) / DWELL) % ow(k);
        return m_sel[k];
    endfunction

    function automatic logic [31:0] m_y(int k);
        return m_act[k] ? (32'd1 << m_idx(k)) : 32'd0;
    endfunction

    function automatic bit m_wrap(int k);
        return m_act[k] && m_mode[k] == 2 && m_t[k] > 1 &&
               ((m_t[k] - 1) % DWELL) == 0 && m_idx(k) == 0;
    endfunction

    task automatic model_step(int k);
        bit rdy = m_ready(k);
        if (!d_en[k]) begin
            m_act[k] = 1'b0;
        end else if (d_lv[k] && rdy) begin
            m_act[k]  = 1'b1;
            m_mode[k] = (d_mode[k] == 2'd3) ? 0 : int'(d_mode[k]);
            m_sel[k]  = int'(d_sel[k]) % ow(k);
            m_t[k]    = 1;
        end else if (m_act[k]) begin
            m_t[k]++;
            if (m_mode[k] == 1 && m_t[k] > PULSE_LEN) m_act[k] = 1'b0;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(int k, logic en, logic lv, logic [1:0] md, logic [3:0] s);
        d_en[k]   = en;
        d_lv[k]   = lv;
        d_mode[k] = md;
        d_sel[k]  = s;
    endtask

    task automatic check_outputs();
        chk("y3",    32'(bus3.y),    m_y(0));
        chk("idx3",  32'(bus3.idx),  32'(m_idx(0)));
        chk("busy3", 32'(bus3.busy), 32'(m_act[0]));
        chk("wrap3", 32'(bus3.wrap), 32'(m_wrap(0)));
        chk("y4",    32'(bus4.y),    m_y(1));
        chk("idx4",  32'(bus4.idx),  32'(m_idx(1)));
        chk("busy4", 32'(bus4.busy), 32'(m_act[1]));
        chk("wrap4", 32'(bus4.wrap), 32'(m_wrap(1)));
    endtask

    task automatic cycle();
        #1;
        chk("ready3", 32'(bus3.load_ready), 32'(m_ready(0)));
        chk("ready4", 32'(bus4.load_ready), 32'(m_ready(1)));
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    int scan_seq [12] = '{6, 6, 6, 6, 7, 7, 7, 7, 0, 0, 0, 0};

    initial begin
        for (int k = 0; k < 2; k++) begin
            drive(k, 1'b0, 1'b0, 2'd0, 4'd0);
            m_act[k] = 1'b0; m_mode[k] = 0; m_sel[k] = 0; m_t[k] = 0;
        end
        d_en[0] = 1'b1;
        #2;
        chk("rst_y",     32'(bus3.y),          32'h0);
        chk("rst_idx",   32'(bus3.idx),        32'h0);
        chk("rst_busy",  32'(bus3.busy),       32'h0);
        chk("rst_wrap",  32'(bus3.wrap),       32'h0);
        chk("rst_ready", 32'(bus3.load_ready), 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // HOLD sel=5
        drive(0, 1'b1, 1'b1, 2'd0, 4'd5);
        cycle();
        chk("hold_y", 32'(bus3.y), 32'h20);
        chk("hold_idx", 32'(bus3.idx), 32'd5);
        chk("hold_busy", 32'(bus3.busy), 32'd1);
        d_lv[0] = 1'b0;
        repeat (3) cycle();
        chk("hold_stay", 32'(bus3.y), 32'h20);

        // PULSE sel=2 with a HOLD sel=3 request held behind it
        drive(0, 1'b1, 1'b1, 2'd1, 4'd2);
        cycle();
        chk("pulse_y1", 32'(bus3.y), 32'h04);
        drive(0, 1'b1, 1'b1, 2'd0, 4'd3);
        #1 chk("pulse_rdy1", 32'(bus3.load_ready), 32'd0);
        cycle();
        chk("pulse_y2", 32'(bus3.y), 32'h04);
        chk("pulse_rdy2", 32'(bus3.load_ready), 32'd0);
        cycle();
        chk("pulse_end_y", 32'(bus3.y), 32'h00);
        chk("pulse_end_busy", 32'(bus3.busy), 32'd0);
        chk("pulse_end_rdy", 32'(bus3.load_ready), 32'd1);
        cycle();
        chk("pulse_next_y", 32'(bus3.y), 32'h08);

        // SCAN sel=6, then HOLD sel=1 while idx=3
        drive(0, 1'b1, 1'b1, 2'd2, 4'd6);
        cycle();
        d_lv[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("scan_idx", 32'(bus3.idx), 32'(scan_seq[i]));
            chk("scan_wrap", 32'(bus3.wrap), (i == 8) ? 32'd1 : 32'd0);
            cycle();
        end
        repeat (9) cycle();
        chk("scan_at3", 32'(bus3.y), 32'h08);
        drive(0, 1'b1, 1'b1, 2'd0, 4'd1);
        cycle();
        chk("restart_y", 32'(bus3.y), 32'h02);

        // en dropped mid-PULSE
        drive(0, 1'b1, 1'b1, 2'd1, 4'd4);
        cycle();
        chk("pulse4_y", 32'(bus3.y), 32'h10);
        drive(0, 1'b0, 1'b1, 2'd1, 4'd4);
        #1 chk("en_lo_rdy", 32'(bus3.load_ready), 32'd0);
        cycle();
        chk("en_lo_y", 32'(bus3.y), 32'h00);
        chk("en_lo_busy", 32'(bus3.busy), 32'd0);
        drive(0, 1'b1, 1'b0, 2'd1, 4'd4);
        repeat (3) cycle();
        chk("no_resume", 32'(bus3.busy), 32'd0);

        // Reserved mode acts as HOLD
        drive(0, 1'b1, 1'b1, 2'd3, 4'd7);
        cycle();
        d_lv[0] = 1'b0;
        repeat (5) cycle();
        chk("rsvd_y", 32'(bus3.y), 32'h80);

        // Asynchronous reset mid-SCAN
        drive(0, 1'b1, 1'b1, 2'd2, 4'd1);
        cycle();
        d_lv[0] = 1'b0;
        repeat (6) cycle();
        chk("pre_rst_busy", 32'(bus3.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_y", 32'(bus3.y), 32'h0);
        chk("arst_idx", 32'(bus3.idx), 32'h0);
        chk("arst_busy", 32'(bus3.busy), 32'h0);
        m_act[0] = 1'b0;
        m_act[1] = 1'b0;
        #7 rst_n = 1'b1;
        repeat (3) cycle();
        chk("arst_no_resume", 32'(bus3.busy), 32'd0);

        // Random traffic on the 4-bit instance
        d_en[0] = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            drive(1, ($urandom % 16) != 0, ($urandom % 3) == 0,
                  2'($urandom % 4), 4'($urandom % 16));
            cycle();
            chk("onehot0", 32'($onehot0(bus4.y)), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
